// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: PC generation, imem req/ack handshake, stall hold
// buffer and redirect handling with NOP bubble insertion.
module fetch_ctrl #(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_in,
    input  logic             redirect_in,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             valid_out,
    output logic             latch_en
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        STALL = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pend_pc;
    logic [WIDTH-1:0] hold_instr;
    logic [WIDTH-1:0] hold_pc;
    logic             hold_vld;

    logic [WIDTH-1:0] redir_tgt;
    logic [WIDTH-1:0] pc_inc;

    // Redirect targets are word aligned; sequential PC wraps naturally.
    assign redir_tgt = {redirect_pc[WIDTH-1:2], 2'b00};
    assign pc_inc    = pc + WIDTH'(4);

    // The request address is always the PC register, stable while waiting.
    assign imem_addr = pc;

    // Fetch FSM with registered request and fetch-latch outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend_pc    <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
            hold_vld   <= 1'b0;
            imem_req   <= 1'b0;
            instr_out  <= NOP;
            pc_out     <= '0;
            valid_out  <= 1'b0;
            latch_en   <= 1'b0;
        end else begin
            // Default: outputs hold and the fetch latch is not loaded.
            latch_en <= 1'b0;

            case (state)
                // One idle cycle after reset; an ack here is ignored.
                IDLE: begin
                    if (redirect_in) begin
                        pc <= redir_tgt;
                    end
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end

                FETCH: begin
                    if (redirect_in) begin
                        instr_out <= NOP;
                        valid_out <= 1'b0;
                        latch_en  <= 1'b1;
                        imem_req  <= 1'b1;
                        if (imem_ack) begin
                            // Response is wrong-path; restart at the target.
                            pc    <= redir_tgt;
                            state <= FETCH;
                        end else begin
                            // Outstanding request must complete first.
                            pend_pc <= redir_tgt;
                            state   <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc <= pc_inc;
                        if (stall_in) begin
                            hold_instr <= imem_rdata;
                            hold_pc    <= pc;
                            hold_vld   <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= STALL;
                        end else begin
                            instr_out <= imem_rdata;
                            pc_out    <= pc;
                            valid_out <= 1'b1;
                            latch_en  <= 1'b1;
                            imem_req  <= 1'b1;
                            state     <= FETCH;
                        end
                    end else begin
                        imem_req <= 1'b1;
                        state    <= FETCH;
                        if (!stall_in) begin
                            instr_out <= NOP;
                            valid_out <= 1'b0;
                            latch_en  <= 1'b1;
                        end
                    end
                end

                // Waiting for the abandoned request to return before redirecting.
                DRAIN: begin
                    imem_req <= 1'b1;
                    if (redirect_in) begin
                        instr_out <= NOP;
                        valid_out <= 1'b0;
                        latch_en  <= 1'b1;
                        if (imem_ack) begin
                            pc    <= redir_tgt;
                            state <= FETCH;
                        end else begin
                            pend_pc <= redir_tgt;
                            state   <= DRAIN;
                        end
                    end else begin
                        if (!stall_in) begin
                            instr_out <= NOP;
                            valid_out <= 1'b0;
                            latch_en  <= 1'b1;
                        end
                        if (imem_ack) begin
                            pc    <= pend_pc;
                            state <= FETCH;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end

                // Holding one fetched instruction until downstream accepts it.
                STALL: begin
                    if (redirect_in) begin
                        hold_vld  <= 1'b0;
                        pc        <= redir_tgt;
                        instr_out <= NOP;
                        valid_out <= 1'b0;
                        latch_en  <= 1'b1;
                        imem_req  <= 1'b1;
                        state     <= FETCH;
                    end else if (!stall_in) begin
                        instr_out <= hold_instr;
                        pc_out    <= hold_pc;
                        valid_out <= hold_vld;
                        latch_en  <= 1'b1;
                        hold_vld  <= 1'b0;
                        imem_req  <= 1'b1;
                        state     <= FETCH;
                    end else begin
                        imem_req <= 1'b0;
                        state    <= STALL;
                    end
                end

                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle vector table plus an in-order scoreboard
// of instructions expected at the fetch latch.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        latch_en;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_latch;
        logic        exp_valid;
        logic        push;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .redirect_in (redirect_in),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out),
        .latch_en    (latch_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic d,
                                input logic [31:0] rpc, input logic a,
                                input logic [31:0] rd, input logic req,
                                input logic [31:0] addr, input logic le,
                                input logic vo, input logic p);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = d; v.rpc = rpc; v.ack = a;
        v.rdata = rd; v.exp_req = req; v.exp_addr = addr;
        v.exp_latch = le; v.exp_valid = vo; v.push = p;
        return v;
    endfunction

    // Apply one vector for one clock cycle and check pre- and post-edge state.
    task automatic step(input int idx, input vec_t v);
        logic [31:0] p_instr, p_pc;
        logic        p_valid;
        sb_t         e;
        @(negedge clk);
        rst         = v.rst;
        stall_in    = v.stall;
        redirect_in = v.redir;
        redirect_pc = v.rpc;
        imem_ack    = v.ack;
        imem_rdata  = v.rdata;
        #1;
        chk($sformatf("v%0d imem_req", idx), 32'(imem_req), 32'(v.exp_req));
        chk($sformatf("v%0d imem_addr", idx), imem_addr, v.exp_addr);
        if (v.push) begin
            e.instr = v.rdata;
            e.pc    = v.exp_addr;
            sb.push_back(e);
        end
        p_instr = instr_out;
        p_pc    = pc_out;
        p_valid = valid_out;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d latch_en", idx), 32'(latch_en), 32'(v.exp_latch));
        if (v.exp_latch)
            chk($sformatf("v%0d valid_out", idx), 32'(valid_out), 32'(v.exp_valid));
        if ((v.exp_latch && !v.exp_valid) || v.rst)
            chk($sformatf("v%0d bubble instr", idx), instr_out, NOP);
        if (v.rst) begin
            chk($sformatf("v%0d rst valid", idx), 32'(valid_out), 32'd0);
            chk($sformatf("v%0d rst pc_out", idx), pc_out, 32'd0);
            chk($sformatf("v%0d rst imem_req", idx), 32'(imem_req), 32'd0);
        end else if (!v.exp_latch) begin
            chk($sformatf("v%0d hold instr", idx), instr_out, p_instr);
            chk($sformatf("v%0d hold pc", idx), pc_out, p_pc);
            chk($sformatf("v%0d hold valid", idx), 32'(valid_out), 32'(p_valid));
        end
        if (valid_out && latch_en) begin
            if (sb.size() == 0) begin
                chk($sformatf("v%0d unexpected instr", idx), pc_out, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d sb instr", idx), instr_out, e.instr);
                chk($sformatf("v%0d sb pc", idx), pc_out, e.pc);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;

        //             rst st rd rpc            ack rdata          req addr          le vo push
        // Reset then streaming
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA5A5A5A5,  1, 32'h0,         1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA5A5A5A1,  1, 32'h4,         1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA5A5A5AD,  1, 32'h8,         1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA5A5A5A9,  1, 32'hC,         1, 1, 1));
        // Redirect with ack, then slow memory at 8
        vecs.push_back(mk(0, 0, 1, 32'h8,         1, 32'hBAD0BAD0,  1, 32'h10,        1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h05002030,  1, 32'h8,         1, 1, 1));
        // Stall during ack at 4
        vecs.push_back(mk(0, 0, 1, 32'h4,         1, 32'hBAD1BAD1,  1, 32'hC,         1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h11111111,  1, 32'h4,         0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h8,         0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h8,         0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8,         1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h22222222,  1, 32'h8,         1, 1, 1));
        // Redirect while waiting at C, ack two cycles later
        vecs.push_back(mk(0, 0, 1, 32'h100,       0, 32'h0,         1, 32'hC,         1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'hC,         1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'hDEADBEEF,  1, 32'hC,         1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h33333333,  1, 32'h100,       1, 1, 1));
        // Redirect in STALL with buffered pc 0x10, unaligned target
        vecs.push_back(mk(0, 0, 1, 32'h10,        1, 32'hBAD2BAD2,  1, 32'h104,       1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h44444444,  1, 32'h10,        0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h203,       0, 32'h0,         0, 32'h14,        1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h55555555,  1, 32'h200,       1, 1, 1));
        // Wrap and mid-run reset
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC,  1, 32'hBAD3BAD3,  1, 32'h204,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h66666666,  1, 32'hFFFFFFFC,  1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'hBAD4BAD4,  0, 32'h0,         0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA5A5A5A5,  1, 32'h0,         1, 1, 1));
        // Back-to-back redirects in DRAIN: newest target wins
        vecs.push_back(mk(0, 0, 1, 32'h300,       0, 32'h0,         1, 32'h4,         1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h400,       0, 32'h0,         1, 32'h4,         1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'hBAD5BAD5,  1, 32'h4,         0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h77777777,  1, 32'h400,       1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h404,       0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h404,       1, 0, 0));

        // Reset state after two reset cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset imem_req", 32'(imem_req), 32'd0);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset instr_out", instr_out, NOP);
        chk("reset pc_out", pc_out, 32'h0);
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset latch_en", 32'(latch_en), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i]);
        end

        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
